imm_gen_pipe: RTL

//  Registered immediate generator for the decode stage. Decodes every RV32I/RV64I

---
 rtl/imm_gen_pipe.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator for the decode stage.
// Valid/ready pipeline slot with optional 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  logic        s;
  logic        is_i, is_s, is_b, is_u, is_j, is_z;
  logic [31:0] imm32;
  logic        ill;
  logic [XLEN-1:0] imm_x;
  ent_t        ent_in;

  logic        unused_opc;

  assign s    = in_instr[31];
  assign is_i = (in_imm_src == 3'b000);
  assign is_s = (in_imm_src == 3'b001);
  assign is_b = (in_imm_src == 3'b010);
  assign is_u = (in_imm_src == 3'b011);
  assign is_j = (in_imm_src == 3'b100);
  assign is_z = (in_imm_src == 3'b101);

  assign unused_opc = ^in_instr[6:0];

  always_comb begin
    imm32 = '0;
    ill   = 1'b0;
    unique case (1'b1)
      is_i: imm32 = {{20{s}}, in_instr[31:20]};
      is_s: imm32 = {{20{s}}, in_instr[31:25],
                     in_instr[11:7]};
      is_b: imm32 = {{20{s}}, in_instr[7],
                     in_instr[30:25],
                     in_instr[11:8], 1'b0};
      is_u: imm32 = {in_instr[31:12], 12'b0};
      is_j: imm32 = {{12{s}}, in_instr[19:12],
                     in_instr[20],
                     in_instr[30:21], 1'b0};
      is_z: imm32 = {27'b0, in_instr[19:15]};
      default: ill = 1'b1;
    endcase
  end

  // Every format is already sign-correct at bit 31, so one extension suffices.
  if (XLEN == 64) begin : g_x64
    assign imm_x = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm_x = imm32;
  end

  assign ent_in.imm = imm_x;
  assign ent_in.tag = in_tag;
  assign ent_in.ill = ill;

  logic in_xfer;
  logic out_xfer;
  ent_t main_q, main_d;
  logic main_v_q, main_v_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = main_v_q && out_ready;

  if (SKID != 0) begin : g_skid
    ent_t skid_q, skid_d;
    logic skid_v_q, skid_v_d;

    always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (flush) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end else if (!main_v_q) begin
        if (in_xfer) begin
          main_d   = ent_in;
          main_v_d = 1'b1;
        end
      end else if (out_xfer) begin
        if (skid_v_q) begin
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end else if (in_xfer) begin
          main_d = ent_in;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (in_xfer) begin
        skid_d   = ent_in;
        skid_v_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        skid_q   <= '0;
        skid_v_q <= 1'b0;
      end else begin
        skid_q   <= skid_d;
        skid_v_q <= skid_v_d;
      end
    end

    // in_ready comes straight from a flop: no path from out_ready.
    assign in_ready = !skid_v_q;
  end else begin : g_single
    always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      if (flush) begin
        main_v_d = 1'b0;
      end else if (in_xfer) begin
        main_d   = ent_in;
        main_v_d = 1'b1;
      end else if (out_xfer) begin
        main_v_d = 1'b0;
      end
    end

    assign in_ready = !main_v_q || out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q   <= '0;
      main_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      main_v_q <= main_v_d;
    end
  end

  assign out_valid   = main_v_q;
  assign out_imm     = main_q.imm;
  assign out_tag     = main_q.tag;
  assign out_illegal = main_q.ill;

endmodule
